// File: rtl/if_fetch_if.sv
// Instruction-memory fetch bus between if_fetch (master) and instruction memory (slave).
// Handshake: mem_req_o stays high with mem_addr_o stable until the cycle mem_gnt_i=1
// (request accepted on that edge); the response arrives later as a single-cycle mem_rvalid_i
// with mem_rdata_i, and there is at most one request outstanding.
interface if_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: fetches from instruction memory, buffers one held response and
// drives the IF/ID pipeline register; reports fetch stalls to ctrl.
module if_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [4:0]        hold_en_i,
  input  logic              flush_i,
  if_fetch_if.master        mem,
  output logic              fetch_stall_o,
  output logic [DATA_W-1:0] if_inst_o,
  output logic [ADDR_W-1:0] if_instaddr_o,
  output logic              if_valid_o,
  output logic [1:0]        state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              kill_q;
  logic              buf_valid_q;
  logic [DATA_W-1:0] buf_inst_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] instaddr_q;
  logic              valid_q;

  logic              hold;
  logic              rsp;
  logic              rsp_live;
  logic              consume;
  logic [ADDR_W-1:0] pc_aligned;
  logic              unused_inputs;

  assign hold          = hold_en_i[1];
  assign pc_aligned    = {pc_i[ADDR_W-1:2], 2'b00};
  assign unused_inputs = ^{hold_en_i[4:2], hold_en_i[0], pc_i[1:0]};

  // rsp_live excludes the response of a request that was in flight when a flush hit.
  assign rsp      = (state_q == S_RESP) & mem.mem_rvalid_i;
  assign rsp_live = rsp & ~kill_q;
  assign consume  = rsp_live & ~hold & ~flush_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      kill_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!buf_valid_q) begin
            state_q <= S_REQ;
            addr_q  <= pc_aligned;
          end
        end
        S_REQ: begin
          if (flush_i) kill_q <= 1'b1;
          if (mem.mem_gnt_i) state_q <= S_RESP;
        end
        S_RESP: begin
          if (mem.mem_rvalid_i) begin
            kill_q <= 1'b0;
            // Back-to-back only when decode takes the instruction right now.
            if (consume) begin
              state_q <= S_REQ;
              addr_q  <= pc_aligned;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (flush_i) begin
            kill_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inst_q      <= NOP_INST;
      instaddr_q  <= '0;
      valid_q     <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_inst_q  <= NOP_INST;
      buf_addr_q  <= '0;
    end else if (flush_i) begin
      inst_q      <= NOP_INST;
      valid_q     <= 1'b0;
      buf_valid_q <= 1'b0;
    end else if (hold) begin
      if (rsp_live) begin
        buf_valid_q <= 1'b1;
        buf_inst_q  <= mem.mem_rdata_i;
        buf_addr_q  <= addr_q;
      end
    end else if (buf_valid_q) begin
      inst_q      <= buf_inst_q;
      instaddr_q  <= buf_addr_q;
      valid_q     <= 1'b1;
      buf_valid_q <= 1'b0;
    end else if (rsp_live) begin
      inst_q     <= mem.mem_rdata_i;
      instaddr_q <= addr_q;
      valid_q    <= 1'b1;
    end else begin
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end
  end

  // A flush redirects the PC immediately, so the stall is dropped while it is asserted.
  assign fetch_stall_o = rstn & ~flush_i &
                         ((state_q == S_REQ) |
                          ((state_q == S_RESP) & ~mem.mem_rvalid_i) |
                          ((state_q == S_IDLE) & ~buf_valid_q));

  assign mem.mem_req_o  = (state_q == S_REQ);
  assign mem.mem_addr_o = addr_q;
  assign if_inst_o      = inst_q;
  assign if_instaddr_o  = instaddr_q;
  assign if_valid_o     = valid_q;
  assign state_o        = state_q;

endmodule
